// File: rtl/alu_op_sequencer_if.sv
// Handshake and bus bundle between the instruction source, the sequencer, the ALU and the result consumer.
// The slave modport is the sequencer's view; master is the environment around it.
interface alu_op_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_opA;
    logic [31:0] in_opB;
    logic [31:0] in_pc;

    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [4:0]  alu_opcode;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_isNotEqual;
    logic        alu_isLessThan;
    logic        alu_overflow;

    logic        out_valid;
    logic        out_ready;
    logic        out_wen;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_branch;
    logic [31:0] out_target;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, in_opA, in_opB, in_pc,
        input  alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow,
        input  out_ready,
        output in_ready,
        output alu_operandA, alu_operandB, alu_opcode, alu_shamt,
        output out_valid, out_wen, out_rd, out_data, out_branch, out_target, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_opA, in_opB, in_pc,
        output alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow,
        output out_ready,
        input  in_ready,
        input  alu_operandA, alu_operandB, alu_opcode, alu_shamt,
        input  out_valid, out_wen, out_rd, out_data, out_branch, out_target, out_illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one instruction at a time through an external ALU and returns a registered result packet.
// EXEC lasts two cycles: load the ALU drive registers, then capture the ALU outputs.
module alu_op_sequencer #(
    parameter logic [4:0] RSTATUS = 5'd30
) (
    input logic           clock,
    input logic           reset,
    alu_op_sequencer_if.slave bus
);
    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state_q;
    logic        ph_q;
    logic [4:0]  opc_q, rdf_q;
    logic [16:0] imm_q;
    logic [31:0] opa_q, opb_q, pc_q;
    logic [31:0] alu_a_q, alu_b_q, alu_a_d, alu_b_d;
    logic [4:0]  alu_op_q, alu_sh_q, alu_op_d, alu_sh_d;
    logic        valid_q, wen_q, branch_q, illegal_q;
    logic        wen_d, branch_d, illegal_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d, target_q, target_d;

    logic [4:0]  aluop, shamt;
    logic [31:0] simm;
    logic        in_ready, accept;

    assign aluop    = imm_q[6:2];
    assign shamt    = imm_q[11:7];
    assign simm     = {{15{imm_q[16]}}, imm_q};
    assign in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        alu_a_d  = opa_q;
        alu_b_d  = opb_q;
        alu_op_d = 5'd1;
        alu_sh_d = 5'd0;
        case (opc_q)
            OP_R:    begin alu_op_d = aluop; alu_sh_d = shamt; end
            OP_ADDI: begin alu_b_d = simm; alu_op_d = 5'd0; end
            default: ;
        endcase
    end

    // Overflow on add/sub/addi redirects the write to the status register with a cause code.
    always_comb begin
        wen_d     = 1'b0;
        rd_d      = rdf_q;
        data_d    = 32'd0;
        branch_d  = 1'b0;
        target_d  = 32'd0;
        illegal_d = 1'b0;
        case (opc_q)
            OP_R: begin
                if (aluop <= 5'd5) begin
                    wen_d  = 1'b1;
                    data_d = bus.alu_result;
                    if (bus.alu_overflow && aluop == 5'd0) begin
                        rd_d = RSTATUS; data_d = 32'd1;
                    end else if (bus.alu_overflow && aluop == 5'd1) begin
                        rd_d = RSTATUS; data_d = 32'd3;
                    end
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_ADDI: begin
                wen_d  = 1'b1;
                data_d = bus.alu_result;
                if (bus.alu_overflow) begin
                    rd_d = RSTATUS; data_d = 32'd2;
                end
            end
            OP_BNE: begin
                branch_d = bus.alu_isNotEqual;
                target_d = pc_q + 32'd1 + simm;
            end
            OP_BLT: begin
                branch_d = bus.alu_isLessThan;
                target_d = pc_q + 32'd1 + simm;
            end
            default: illegal_d = 1'b1;
        endcase
        if (rd_d == 5'd0) wen_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ph_q      <= 1'b0;
            opc_q     <= '0;
            rdf_q     <= '0;
            imm_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            pc_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            alu_sh_q  <= '0;
            valid_q   <= 1'b0;
            wen_q     <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            branch_q  <= 1'b0;
            target_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                EXEC: begin
                    if (!ph_q) begin
                        alu_a_q  <= alu_a_d;
                        alu_b_q  <= alu_b_d;
                        alu_op_q <= alu_op_d;
                        alu_sh_q <= alu_sh_d;
                        ph_q     <= 1'b1;
                    end else begin
                        wen_q     <= wen_d;
                        rd_q      <= rd_d;
                        data_q    <= data_d;
                        branch_q  <= branch_d;
                        target_q  <= target_d;
                        illegal_q <= illegal_d;
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: ;
            endcase
            // A new accept overrides the DONE->IDLE exit so the next instruction starts on the same edge.
            if (accept) begin
                opc_q   <= bus.in_instr[31:27];
                rdf_q   <= bus.in_instr[26:22];
                imm_q   <= bus.in_instr[16:0];
                opa_q   <= bus.in_opA;
                opb_q   <= bus.in_opB;
                pc_q    <= bus.in_pc;
                ph_q    <= 1'b0;
                state_q <= EXEC;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.alu_operandA = alu_a_q;
    assign bus.alu_operandB = alu_b_q;
    assign bus.alu_opcode   = alu_op_q;
    assign bus.alu_shamt    = alu_sh_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_wen      = wen_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_data     = data_q;
    assign bus.out_branch   = branch_q;
    assign bus.out_target   = target_q;
    assign bus.out_illegal  = illegal_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: a reference model predicts each packet at accept time; a monitor compares on output.
module tb_alu_op_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ovf_force = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nmis = 0;
    bit   seen = 1'b0;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.RSTATUS(5'd30)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural ALU: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra.
    always_comb begin
        logic [31:0] a, b;
        a = bus.alu_operandA;
        b = bus.alu_operandB;
        bus.alu_result   = 32'd0;
        bus.alu_overflow = ovf_force;
        case (bus.alu_opcode)
            5'd0: begin
                bus.alu_result = a + b;
                if (a[31] == b[31] && bus.alu_result[31] != a[31]) bus.alu_overflow = 1'b1;
            end
            5'd1: begin
                bus.alu_result = a - b;
                if (a[31] != b[31] && bus.alu_result[31] != a[31]) bus.alu_overflow = 1'b1;
            end
            5'd2: bus.alu_result = a & b;
            5'd3: bus.alu_result = a | b;
            5'd4: bus.alu_result = a << bus.alu_shamt;
            5'd5: bus.alu_result = $signed(a) >>> bus.alu_shamt;
            default: ;
        endcase
        bus.alu_isNotEqual = (a != b);
        bus.alu_isLessThan = ($signed(a) < $signed(b));
    end

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        branch;
        logic [31:0] target;
        logic        illegal;
        logic        is_br;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] aluop, input logic [4:0] sh);
        return {5'd0, rd, 5'd0, 5'd0, sh, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd, input logic [16:0] imm);
        return {op, rd, 5'd0, imm};
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic fo);
        exp_t        e;
        logic [4:0]  op, rd, aop, sh;
        logic [31:0] s, r;
        logic        ov;
        op = ins[31:27]; rd = ins[26:22]; aop = ins[6:2]; sh = ins[11:7];
        s  = {{15{ins[16]}}, ins[16:0]};
        e = '{wen: 1'b0, rd: rd, data: 32'd0, branch: 1'b0, target: 32'd0, illegal: 1'b0, is_br: 1'b0, acc: 0};
        if (op == 5'd0 && aop <= 5'd5) begin
            ov = 1'b0;
            case (aop)
                5'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
                5'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
                5'd2: r = a & b;
                5'd3: r = a | b;
                5'd4: r = a << sh;
                default: r = $signed(a) >>> sh;
            endcase
            e.wen = 1'b1; e.data = r;
            if ((ov || fo) && aop == 5'd0) begin e.rd = 5'd30; e.data = 32'd1; end
            if ((ov || fo) && aop == 5'd1) begin e.rd = 5'd30; e.data = 32'd3; end
        end else if (op == 5'd5) begin
            r = a + s;
            e.wen = 1'b1; e.data = r;
            if (fo || ((a[31] == s[31]) && (r[31] != a[31]))) begin e.rd = 5'd30; e.data = 32'd2; end
        end else if (op == 5'd2 || op == 5'd6) begin
            e.is_br  = 1'b1;
            e.branch = (op == 5'd2) ? (a != b) : ($signed(a) < $signed(b));
            e.target = pc + 32'd1 + s;
        end else begin
            e.illegal = 1'b1;
        end
        if (e.rd == 5'd0) e.wen = 1'b0;
        return e;
    endfunction

    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_opA = a; bus.in_opB = b; bus.in_pc = pc;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clock); #1; n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
        end else begin
            e = model(ins, a, b, pc, ovf_force);
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock); n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
        @(negedge clock);
    endtask

    // Monitor: latency on first sight, full packet every cycle it is offered (covers stall stability).
    always @(negedge clock) begin
        exp_t e;
        #1;
        if (!reset) begin
            exp_q.delete();
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                e = exp_q[0];
                if (!seen) begin
                    chk("latency", cyc - e.acc, 32'd2);
                    seen = 1'b1;
                end
                chk("out_wen", {31'd0, bus.out_wen}, {31'd0, e.wen});
                chk("out_branch", {31'd0, bus.out_branch}, {31'd0, e.branch});
                chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, e.illegal});
                if (e.wen) begin
                    chk("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
                    chk("out_data", bus.out_data, e.data);
                end
                if (e.is_br) chk("out_target", bus.out_target, e.target);
                if (!bus.out_ready) chk("in_ready_stall", {31'd0, bus.in_ready}, 32'd0);
                else begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_opA = '0; bus.in_opB = '0; bus.in_pc = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_wen", {31'd0, bus.out_wen}, 32'd0);
        chk("rst_out_branch", {31'd0, bus.out_branch}, 32'd0);
        chk("rst_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
        chk("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_target", bus.out_target, 32'd0);
        chk("rst_alu_a", bus.alu_operandA, 32'd0);
        chk("rst_alu_op", {27'd0, bus.alu_opcode}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        reset = 1'b1;

        // ALU ops, overflow redirects, addi
        send(rtype(5'd3, 5'd0, 5'd0), 32'd5, 32'd7, 32'd0);
        drain();
        send(rtype(5'd8, 5'd1, 5'd0), 32'd20, 32'd27, 32'd0);
        send(rtype(5'd9, 5'd2, 5'd0), 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);
        send(rtype(5'd10, 5'd3, 5'd0), 32'hF000_0001, 32'h0000_0F10, 32'd0);
        send(rtype(5'd11, 5'd4, 5'd4), 32'h8000_00FF, 32'd0, 32'd0);
        send(rtype(5'd12, 5'd5, 5'd8), 32'h8123_4500, 32'd0, 32'd0);
        send(rtype(5'd13, 5'd0, 5'd0), 32'h7FFF_FFFF, 32'd1, 32'd0);
        send(rtype(5'd14, 5'd1, 5'd0), 32'h8000_0000, 32'd1, 32'd0);
        send(itype(5'd5, 5'd4, 17'd1), 32'h7FFF_FFFF, 32'd0, 32'd0);
        send(itype(5'd5, 5'd15, 17'h1FFFB), 32'd100, 32'd0, 32'd0);
        // branches, including target wrap
        send(itype(5'd6, 5'd0, 17'h1FFFD), 32'hFFFF_FFFF, 32'd0, 32'd10);
        send(itype(5'd2, 5'd1, 17'd4), 32'd9, 32'd9, 32'd20);
        send(itype(5'd2, 5'd1, 17'd4), 32'd1, 32'd2, 32'd20);
        send(itype(5'd6, 5'd1, 17'd0), 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        // illegal encodings and rd=0
        send(itype(5'd31, 5'd7, 17'd0), 32'd1, 32'd2, 32'd0);
        send(rtype(5'd7, 5'd6, 5'd0), 32'd1, 32'd2, 32'd0);
        send(rtype(5'd0, 5'd0, 5'd0), 32'd1, 32'd2, 32'd0);
        drain();

        // overflow flag honoured only on add/sub/addi
        ovf_force = 1'b1;
        send(rtype(5'd5, 5'd2, 5'd0), 32'hFF, 32'h0F, 32'd0);
        send(rtype(5'd6, 5'd4, 5'd1), 32'd3, 32'd0, 32'd0);
        send(rtype(5'd16, 5'd0, 5'd0), 32'd1, 32'd1, 32'd0);
        send(itype(5'd5, 5'd17, 17'd3), 32'd1, 32'd0, 32'd0);
        send(itype(5'd2, 5'd0, 17'd2), 32'd1, 32'd2, 32'd40);
        drain();
        ovf_force = 1'b0;

        // consumer stall, then back-to-back accept on the release edge
        bus.out_ready = 1'b0;
        send(rtype(5'd18, 5'd0, 5'd0), 32'd40, 32'd2, 32'd0);
        fork
            send(rtype(5'd19, 5'd3, 5'd0), 32'd8, 32'd1, 32'd0);
            begin repeat (8) @(negedge clock); bus.out_ready = 1'b1; end
        join
        drain();

        // reset mid-EXEC discards the in-flight packet
        send(rtype(5'd20, 5'd0, 5'd0), 32'd2, 32'd3, 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_idle", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_mid_alu_a", bus.alu_operandA, 32'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock); #1;
            chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        send(rtype(5'd21, 5'd0, 5'd0), 32'd11, 32'd22, 32'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter RSTATUS, default 5'd30, meaning the destination register for overflow status writes.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  instruction offered.
REQ-005 SHALL have port in_ready  output  1  sequencer accepts the instruction this cycle.
REQ-006 SHALL have port in_instr  input  32  instruction word: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], aluop [6:2], imm [16:0].
REQ-007 SHALL have ports in_opA and in_opB  input  32 each  register values for rs (or rd for branches) and rt (or rs for branches).
REQ-008 SHALL have port in_pc  input  32  PC of the instruction.
REQ-009 SHALL have ports alu_operandA and alu_operandB (output, 32), alu_opcode and alu_shamt (output, 5): drive the ALU.
REQ-010 SHALL have ports alu_result (input, 32) and alu_isNotEqual, alu_isLessThan, alu_overflow (input, 1 each): returned by the ALU.
REQ-011 SHALL have port out_valid  output  1  result packet valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the packet.
REQ-013 SHALL have ports out_wen (1), out_rd (5), out_data (32), out_branch (1), out_target (32), out_illegal (1), all outputs: the result packet.

Function
REQ-014 SHALL implement states IDLE, EXEC, DONE; in_ready = (IDLE) or (DONE and out_ready).
REQ-015 SHALL, on the in_valid and in_ready edge, register the instruction, operands and PC and enter EXEC.
REQ-016 SHALL drive the ALU ports only from registered values: R-type (opcode 00000) gives A=opA, B=opB, opcode=aluop, shamt=shamt; addi (00101) gives A=opA, B=sign-extended imm[16:0], opcode 00000; bne (00010) and blt (00110) give A=opA, B=opB, opcode 00001.
REQ-017 SHALL, in EXEC, capture the ALU outputs into the packet registers, then enter DONE with out_valid=1; latency is accept edge + 2 edges.
REQ-018 SHALL hold every packet field stable in DONE until out_valid and out_ready; it then goes to EXEC if a new instruction is accepted on the same edge, else to IDLE.
REQ-019 SHALL, for R-type with aluop 00000-00101 and for addi, set out_wen=1, out_rd=rd and out_data=alu_result.
REQ-020 SHALL, on alu_overflow for R-add, R-sub or addi, set out_rd=RSTATUS and out_data to 1, 3 or 2 respectively, with out_wen=1.
REQ-021 SHALL ignore alu_overflow for and, or, sll, sra and branches.
REQ-022 SHALL, for bne, set out_branch=alu_isNotEqual; for blt, set out_branch=alu_isLessThan (opA<opB signed). Branches set out_wen=0.
REQ-023 SHALL compute out_target = in_pc + 1 + sign-extended imm, mod 2^32 (wrap-around allowed), for every branch, taken or not.
REQ-024 SHALL force out_wen=0 when the final out_rd is 0.
REQ-025 SHALL treat any other opcode, or R-type aluop 00110-11111, as illegal: out_illegal=1, out_wen=0, out_branch=0.
REQ-026 SHALL keep in_ready low in EXEC; in_valid is ignored there.

Reset
REQ-027 SHALL, while reset=0, force state IDLE, out_valid=0, out_wen=0, out_branch=0, out_illegal=0, out_rd=0, out_data=0, out_target=0, and all ALU drive registers to 0, independent of clock.
REQ-028 SHALL, on reset assertion mid-operation (EXEC or DONE), discard the in-flight packet; no out_valid pulse may follow deassertion.

Verification
REQ-029 SHALL cover: R-add, rd=3, opA=5, opB=7 -> out_valid on 2nd edge after accept, out_wen=1, out_rd=3, out_data=12.
REQ-030 SHALL cover: addi, rd=4, opA=32'h7FFFFFFF, imm=1, ALU overflow=1 -> out_rd=30, out_data=2, out_wen=1.
REQ-031 SHALL cover: blt with opA=-1, opB=0, pc=10, imm=-3 -> out_branch=1, out_target=8, out_wen=0; bne with opA=opB=9 -> out_branch=0.
REQ-032 SHALL cover: out_ready held low 5 cycles in DONE -> packet stable and in_ready=0; out_ready and in_valid both high -> back-to-back accept, next packet 2 edges later.
REQ-033 SHALL cover: opcode 11111 -> out_illegal=1, out_wen=0; R-type rd=0 -> out_wen=0.
REQ-034 SHALL cover: reset pulled low in EXEC -> out_valid=0 immediately, state IDLE, no packet after release.
